// File: rtl/dmem_image_loader_pkg.sv
// Shared definitions for the data-memory image loader: FSM encoding,
// frame marker default and the geometry of the mMIPS data memory.
package dmem_image_loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Data memory is 64 banks of 512 words each.
    localparam int DMEM_BANKS      = 64;
    localparam int DMEM_BANK_WORDS = 512;
    localparam int DMEM_WORDS      = DMEM_BANKS * DMEM_BANK_WORDS;
    localparam int DMEM_ADDR_W     = $clog2(DMEM_WORDS);

    // Words arrive big-endian: the three earlier bytes form the top 24 bits.
    function automatic logic [31:0] pack_word(input logic [23:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/dmem_image_loader_word_packer.sv
// Collects four accepted bytes into a big-endian word and pulses
// o_word_valid for one cycle once the word is complete.
module dmem_image_loader_word_packer
    import dmem_image_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_idx,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_word_valid;

    // r_word is only reloaded on a completed word, so it holds between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_flush) begin
                r_shift <= '0;
                r_idx   <= '0;
            end else if (i_byte_valid) begin
                r_shift <= {r_shift[15:0], i_byte};
                r_idx   <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_word       <= pack_word(r_shift, i_byte);
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_idx        = r_idx;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/dmem_image_loader.sv
// Loads a framed, XOR-checksummed byte stream into the mMIPS data memory and
// keeps the processor in reset until a verified image is in place.
module dmem_image_loader
    import dmem_image_loader_pkg::*;
#(
    parameter int         ADDR_W    = DMEM_ADDR_W,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MAX_WORDS = DMEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves when in_valid & in_ready in the same cycle; the
    // source must hold in_data stable while in_valid is high and in_ready low.

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_cnt_hi;
    logic [15:0]        r_left;
    logic [ADDR_W-1:0]  r_word_idx;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [7:0]         r_csum;

    logic               w_xfer;
    logic               w_data_xfer;
    logic               w_flush;
    logic [15:0]        w_count;
    logic               w_count_too_big;
    logic [1:0]         w_idx;
    logic [31:0]        w_word;
    logic               w_word_valid;

    // Stalling only in the write cycle keeps at most one word in flight.
    assign in_ready    = ~w_word_valid;
    assign w_xfer      = in_valid & in_ready;
    assign w_data_xfer = w_xfer && (r_state == ST_DATA);
    assign w_flush     = w_xfer && (r_state == ST_SYNC) && (in_data == SYNC_BYTE);
    assign w_count     = {r_cnt_hi, in_data};
    assign w_count_too_big = {16'd0, w_count} > 32'(MAX_WORDS);

    dmem_image_loader_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (w_flush),
        .i_byte_valid (w_data_xfer),
        .i_byte       (in_data),
        .o_idx        (w_idx),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        done         = 1'b0;
        err          = 1'b0;
        cpu_hold     = 1'b1;
        case (r_state)
            ST_SYNC: begin
                if (w_xfer && (in_data == SYNC_BYTE)) w_next_state = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (w_xfer) w_next_state = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (w_xfer) begin
                    if (w_count_too_big)      w_next_state = ST_ERROR;
                    else if (w_count == 16'd0) w_next_state = ST_CHK;
                    else                       w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                // r_left already counts the word being written this cycle.
                if (w_word_valid && (r_left == 16'd0)) w_next_state = ST_CHK;
            end
            ST_CHK: begin
                if (w_xfer) w_next_state = (in_data == r_csum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (clear) w_next_state = ST_SYNC;
            end
            ST_ERROR: begin
                err = 1'b1;
                if (clear) w_next_state = ST_SYNC;
            end
            default: w_next_state = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_hi   <= '0;
            r_left     <= '0;
            r_word_idx <= '0;
            r_mem_addr <= '0;
            r_csum     <= '0;
        end else begin
            if ((r_state == ST_CNT_HI) && w_xfer) begin
                r_cnt_hi <= in_data;
            end
            if ((r_state == ST_CNT_LO) && w_xfer) begin
                r_left     <= w_count;
                r_word_idx <= '0;
                r_csum     <= '0;
            end
            if (w_data_xfer) begin
                r_csum <= r_csum ^ in_data;
                if (w_idx == 2'd3) begin
                    r_mem_addr <= r_word_idx;
                    r_word_idx <= r_word_idx + ADDR_W'(1);
                    r_left     <= r_left - 16'd1;
                end
            end
            if (((r_state == ST_DONE) || (r_state == ST_ERROR)) && clear) begin
                r_csum <= '0;
            end
        end
    end

    assign mem_we    = w_word_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = w_word;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_image_loader.sv
// Randomized scoreboard bench for dmem_image_loader: frames are built from
// word lists, expected writes are queued and a monitor checks every write.
module tb_dmem_image_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1024;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          clear;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  int ready_viol = 0;
  int write_count = 0;
  bit sim_done = 0;
  bit use_gaps = 0;

  logic [AW+31:0] exp_q[$];
  logic [31:0]    words[$];

  dmem_image_loader #(
    .ADDR_W    (AW),
    .SYNC_BYTE (SYNC),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: checksum is the XOR of every data byte of the image
  function automatic logic [7:0] ref_csum();
    logic [7:0] cs;
    cs = 8'h00;
    foreach (words[i]) cs ^= words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return cs;
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n;
    if (use_gaps) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 50) begin
        check("byte_accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad, input bit clear_mid);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    logic [AW-1:0] a;
    n16 = n[15:0];
    cs  = ref_csum() ^ (bad ? 8'h01 : 8'h00);
    if (n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        a = i[AW-1:0];
        exp_q.push_back({a, words[i]});
      end
    end
    send_byte(SYNC);
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    if (n > MAXW) begin
      check("err_after_count", 64'(err), 64'd1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = words[i];
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      if (clear_mid && i == 0) pulse_clear();
    end
    check("hold_before_chk", 64'(cpu_hold), 64'd1);
    send_byte(cs);
    check("release_after_chk", 64'(cpu_hold), 64'(bad));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_status(input string name, input bit exp_done, input bit exp_err);
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_err"},  64'(err),  64'(exp_err));
    check({name, "_hold"}, 64'(cpu_hold), 64'(!exp_done));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    check({name, "_mem_we"},   64'(mem_we), 64'd0);
    check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({name, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_err"},  64'(err), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; clear = 1'b0;
    fork
      begin : monitor
        while (!sim_done) begin
          @(negedge clk);
          if (!rst) begin
            if (in_ready !== !mem_we) ready_viol++;
            if (mem_we) begin
              write_count++;
              if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
              end else begin
                check("mem_write", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
              end
            end
          end
        end
      end
      begin : stimulus
        int wc0;
        bit bad;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // two-word frame, clear pulse in DATA must be ignored
        words = '{32'hDEADBEEF, 32'h01020304};
        send_frame(2, 1'b0, 1'b1);
        check_status("s1", 1'b1, 1'b0);
        drain("s1_writes");
        // bytes in DONE are dropped
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        repeat (2) begin @(posedge clk); #1; end
        check_status("done_drop", 1'b1, 1'b0);

        // leading junk, zero-length image
        pulse_clear();
        check_status("after_clear", 1'b0, 1'b0);
        words.delete();
        send_byte(8'h11); send_byte(8'h22);
        send_frame(0, 1'b0, 1'b0);
        check_status("s2", 1'b1, 1'b0);
        drain("s2_writes");

        // wrong checksum, then recovery
        pulse_clear();
        words = '{32'hDEADBEEF, 32'h01020304};
        send_frame(2, 1'b1, 1'b0);
        drain("s3_writes");
        check_status("s3_bad", 1'b0, 1'b1);
        pulse_clear();
        send_frame(2, 1'b0, 1'b0);
        drain("s3_retry_writes");
        check_status("s3_retry", 1'b1, 1'b0);

        // oversized counts
        pulse_clear();
        words.delete();
        send_frame(32'h8001, 1'b0, 1'b0);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check_status("s4_big", 1'b0, 1'b1);
        pulse_clear();
        send_frame(MAXW + 1, 1'b0, 1'b0);
        check_status("s4_max_plus1", 1'b0, 1'b1);
        drain("s4_writes");

        // reset in the middle of a frame
        pulse_clear();
        send_byte(SYNC); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        words = '{32'hDEADBEEF, 32'h01020304};
        send_frame(2, 1'b0, 1'b0);
        drain("s5_writes");
        check_status("s5", 1'b1, 1'b0);

        // random frames with random gaps
        use_gaps = 1;
        for (int k = 0; k < 6; k++) begin
          pulse_clear();
          words.delete();
          repeat ($urandom_range(1, 8)) words.push_back($urandom());
          bad = ($urandom_range(0, 3) == 0);
          send_frame(words.size(), bad, 1'b1);
          drain("rand_writes");
          check_status("rand", !bad, bad);
        end

        // full image of MAX_WORDS words
        pulse_clear();
        words.delete();
        for (int i = 0; i < MAXW; i++) words.push_back($urandom());
        wc0 = write_count;
        send_frame(MAXW, 1'b0, 1'b0);
        drain("full_writes");
        check("full_write_count", 64'(write_count - wc0), 64'(MAXW));
        check_status("full", 1'b1, 1'b0);

        check("in_ready_low_only_in_write", 64'(ready_viol), 64'd0);
        sim_done = 1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
